// File: rtl/operand_queue.sv
// operand_queue: FWFT queue of 1..3 byte accumulator result bundles.
// Sticky overflow/malformed flags report dropped and ill-formed pushes.
module operand_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_r0,
    input  logic [7:0]                 in_r1,
    input  logic [7:0]                 in_r2,
    input  logic                       in_r0_valid,
    input  logic                       in_r1_valid,
    input  logic                       in_r2_valid,
    input  logic                       in_done,
    output logic [7:0]                 out_b0,
    output logic [7:0]                 out_b1,
    output logic [7:0]                 out_b2,
    output logic [1:0]                 out_count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       malformed,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [7:0]    mem_b0_q  [DEPTH];
    logic [7:0]    mem_b1_q  [DEPTH];
    logic [7:0]    mem_b2_q  [DEPTH];
    logic [1:0]    mem_cnt_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          mal_q, mal_d;

    logic [2:0]    vld;
    logic [1:0]    in_cnt;
    logic          well_formed;
    logic          bad_pat;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign vld = {in_r2_valid, in_r1_valid, in_r0_valid};

    // Only prefix patterns starting at r0 are legal; all-zero is a silent no-op.
    always_comb begin
        in_cnt      = 2'd0;
        well_formed = 1'b0;
        bad_pat     = 1'b0;
        unique case (vld)
            3'b001: begin in_cnt = 2'd1; well_formed = 1'b1; end
            3'b011: begin in_cnt = 2'd2; well_formed = 1'b1; end
            3'b111: begin in_cnt = 2'd3; well_formed = 1'b1; end
            3'b000: ;
            default: bad_pat = 1'b1;
        endcase
    end

    assign empty    = (level_q == '0);
    assign full     = (level_q == DEPTH_L);
    assign pop      = ~empty & out_ready;
    assign push_req = in_done & well_formed;
    assign push_ok  = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A new error event wins over a same-cycle clear.
        ovf_d = (ovf_q & ~err_clr) | (push_req & full & ~pop);
        mal_d = (mal_q & ~err_clr) | (in_done & bad_pat);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            mal_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            mal_q    <= mal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem_b0_q[wr_ptr_q]  <= in_r0_valid ? in_r0 : 8'h00;
            mem_b1_q[wr_ptr_q]  <= in_r1_valid ? in_r1 : 8'h00;
            mem_b2_q[wr_ptr_q]  <= in_r2_valid ? in_r2 : 8'h00;
            mem_cnt_q[wr_ptr_q] <= in_cnt;
        end
    end

    assign out_valid = ~empty;
    assign out_b0    = empty ? 8'h00 : mem_b0_q[rd_ptr_q];
    assign out_b1    = empty ? 8'h00 : mem_b1_q[rd_ptr_q];
    assign out_b2    = empty ? 8'h00 : mem_b2_q[rd_ptr_q];
    assign out_count = empty ? 2'd0 : mem_cnt_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign malformed = mal_q;

endmodule
